// File: rtl/card_port_arbiter.sv
// Port-B owner for the 16-entry card RAM: round-robin write/read arbitration plus a
// board-clear sweep that fills every location with one latched value.
module card_port_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 6
) (
   input  logic              clk,
   input  logic              reset_bar,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [0:0] {StArb, StClear} state_t;

   state_t            state_q;
   logic              last_rd_q;
   logic              rd_pend_q;
   logic [DATA_W-1:0] clr_val_q;

   logic wr_elig, rd_elig, pick_wr, pick_rd, sweep_last, arb_now;

   // A requester whose grant is still showing cannot be granted again this edge.
   assign wr_elig    = wr_req & ~wr_gnt;
   assign rd_elig    = rd_req & ~rd_gnt;
   assign pick_wr    = wr_elig & (~rd_elig | last_rd_q);
   assign pick_rd    = rd_elig & (~wr_elig | ~last_rd_q);
   assign sweep_last = &mem_addr;
   // Arbitration runs in ARB (unless a clear starts) and on the final sweep edge.
   assign arb_now    = ((state_q == StArb) && !clr_start) || ((state_q == StClear) && sweep_last);

   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         state_q   <= StArb;
         last_rd_q <= 1'b1;
         rd_pend_q <= 1'b0;
         clr_val_q <= '0;
         wr_gnt    <= 1'b0;
         rd_gnt    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         clr_busy  <= 1'b0;
         clr_done  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
      end else begin
         // Read return path: RAM samples the address one edge after the grant,
         // its output is captured on the following edge.
         rd_pend_q <= rd_gnt;
         rd_valid  <= rd_pend_q;
         if (rd_pend_q) begin
            rd_data <= mem_dout;
         end

         wr_gnt   <= 1'b0;
         rd_gnt   <= 1'b0;
         mem_we   <= 1'b0;
         clr_done <= 1'b0;

         case (state_q)
            StArb: begin
               if (clr_start) begin
                  clr_val_q <= clr_data;
                  state_q   <= StClear;
                  clr_busy  <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= '0;
                  mem_din   <= clr_data;
               end
            end
            StClear: begin
               if (sweep_last) begin
                  state_q  <= StArb;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  mem_we   <= 1'b1;
                  mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                  mem_din  <= clr_val_q;
               end
            end
            default: state_q <= StArb;
         endcase

         if (arb_now) begin
            if (pick_wr) begin
               wr_gnt    <= 1'b1;
               mem_we    <= 1'b1;
               mem_addr  <= wr_addr;
               mem_din   <= wr_data;
               last_rd_q <= 1'b0;
            end else if (pick_rd) begin
               rd_gnt    <= 1'b1;
               mem_addr  <= rd_addr;
               last_rd_q <= 1'b1;
            end
         end
      end
   end

endmodule
